// File: rtl/pwm_dac_array.sv
// Multi-channel PWM DAC sharing one period counter, with shadow registers
// committed only at period boundaries and edge- or center-aligned counting.
module pwm_dac_array #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic                      mode,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_end,
    output logic                      update_pending
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [WIDTH-1:0]          sh_period;
    logic [CHANNELS*WIDTH-1:0] sh_duty;
    logic                      sh_mode;
    logic                      pending;

    logic [WIDTH-1:0]          act_period;
    logic [CHANNELS*WIDTH-1:0] act_duty;
    logic                      act_mode;

    logic [WIDTH-1:0]          cnt;
    dir_t                      dir;

    logic                      boundary;
    logic                      commit;
    logic [CHANNELS-1:0]       compare;

    // A zero period makes every enabled cycle a boundary in either mode.
    always_comb begin
        boundary = 1'b0;
        if (enable) begin
            if (act_period == '0)
                boundary = 1'b1;
            else if (!act_mode)
                boundary = (cnt == act_period);
            else
                boundary = (dir == DIR_DOWN) && (cnt == '0);
        end
    end

    assign commit         = boundary && (pending || load);
    assign period_end     = boundary;
    assign update_pending = pending;

    always_comb begin
        compare = '0;
        for (int i = 0; i < CHANNELS; i++)
            compare[i] = enable && (cnt < act_duty[i*WIDTH +: WIDTH]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_period <= '0;
            sh_duty   <= '0;
            sh_mode   <= 1'b0;
            pending   <= 1'b0;
        end else if (load) begin
            sh_period <= period;
            sh_duty   <= duty;
            sh_mode   <= mode;
            pending   <= 1'b1;
        end else if (commit) begin
            pending   <= 1'b0;
        end
    end

    // A load in the boundary cycle itself bypasses the shadow set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_period <= '0;
            act_duty   <= '0;
            act_mode   <= 1'b0;
        end else if (commit) begin
            act_period <= load ? period : sh_period;
            act_duty   <= load ? duty   : sh_duty;
            act_mode   <= load ? mode   : sh_mode;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (enable) begin
            if (boundary) begin
                cnt <= '0;
                dir <= DIR_UP;
            end else if (!act_mode) begin
                cnt <= cnt + 1'b1;
            end else if (dir == DIR_UP) begin
                if (cnt == act_period - 1'b1)
                    dir <= DIR_DOWN;
                else
                    cnt <= cnt + 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pwm_out <= '0;
        else
            pwm_out <= compare;
    end

endmodule

// File: tb/tb_pwm_dac_array.sv
// Randomized bench for pwm_dac_array against a position-in-period model.
module tb_pwm_dac_array;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      enable;
    logic                      load;
    logic                      mode;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_end;
    logic                      update_pending;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: shadow and active settings plus the tick index within the period.
    int                  m_sp, m_sm, m_pa, m_ma, m_t;
    int                  m_sd[CHANNELS];
    int                  m_da[CHANNELS];
    bit                  m_pending;
    logic [CHANNELS-1:0] exp_pwm;

    pwm_dac_array #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .load           (load),
        .mode           (mode),
        .period         (period),
        .duty           (duty),
        .pwm_out        (pwm_out),
        .period_end     (period_end),
        .update_pending (update_pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int period_len();
        if (m_pa == 0)  return 1;
        if (m_ma == 0)  return m_pa + 1;
        return 2 * m_pa;
    endfunction

    // Counter value implied by the position in the period: a ramp, or a triangle
    // in which every value appears once rising and once falling.
    function automatic int model_cnt();
        if (m_ma == 0 || m_pa == 0) return m_t;
        if (m_t < m_pa)             return m_t;
        return 2 * m_pa - 1 - m_t;
    endfunction

    function automatic void model_reset();
        m_sp = 0; m_sm = 0; m_pa = 0; m_ma = 0; m_t = 0;
        m_pending = 1'b0;
        exp_pwm = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            m_sd[i] = 0;
            m_da[i] = 0;
        end
    endfunction

    function automatic logic [CHANNELS*WIDTH-1:0] pack2(input int d0, input int d1);
        logic [CHANNELS*WIDTH-1:0] v;
        v = '0;
        v[0 +: WIDTH]     = WIDTH'(d0);
        v[WIDTH +: WIDTH] = WIDTH'(d1);
        return v;
    endfunction

    // Called with the clock low; drives one cycle, checks it and ends at the next negedge.
    task automatic applyStimulus(input logic en, input logic ld, input logic md,
                                 input int p, input logic [CHANNELS*WIDTH-1:0] dv);
        int  c;
        bit  bnd, cmt;
        enable = en;
        load   = ld;
        mode   = md;
        period = WIDTH'(p);
        duty   = dv;
        #1;
        c   = model_cnt();
        bnd = en && (m_t == period_len() - 1);
        checkOutput("period_end", {31'd0, period_end}, {31'd0, bnd});
        for (int i = 0; i < CHANNELS; i++)
            exp_pwm[i] = en && (c < m_da[i]);
        cmt = bnd && (m_pending || ld);
        if (en) begin
            if (bnd) m_t = 0;
            else     m_t = m_t + 1;
        end
        if (cmt) begin
            m_pa = ld ? p : m_sp;
            m_ma = ld ? int'(md) : m_sm;
            for (int i = 0; i < CHANNELS; i++)
                m_da[i] = ld ? int'(dv[i*WIDTH +: WIDTH]) : m_sd[i];
        end
        if (ld) begin
            m_sp = p;
            m_sm = int'(md);
            for (int i = 0; i < CHANNELS; i++)
                m_sd[i] = int'(dv[i*WIDTH +: WIDTH]);
            m_pending = 1'b1;
        end else if (cmt) begin
            m_pending = 1'b0;
        end
        @(negedge clk);
        checkOutput("pwm_out", {30'd0, pwm_out}, {30'd0, exp_pwm});
        checkOutput("update_pending", {31'd0, update_pending}, {31'd0, m_pending});
    endtask

    // Cycles without load; the period/duty/mode inputs wander to prove they are ignored.
    task automatic runIdle(input logic en, input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(en, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 255),
                          pack2($urandom_range(0, 255), $urandom_range(0, 255)));
    endtask

    initial begin
        int p;
        model_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        mode    = 1'b0;
        period  = '0;
        duty    = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset pwm_out", {30'd0, pwm_out}, 32'd0);
        checkOutput("reset update_pending", {31'd0, update_pending}, 32'd0);
        checkOutput("reset period_end", {31'd0, period_end}, 32'd0);
        reset_n = 1'b1;

        // Edge mode, P=9, ch0=3, ch1=0, then a mid-period change to ch0=7.
        applyStimulus(1'b1, 1'b1, 1'b0, 9, pack2(3, 0));
        runIdle(1'b1, 14);
        applyStimulus(1'b1, 1'b1, 1'b0, 9, pack2(7, 0));
        runIdle(1'b1, 25);

        // Center mode, P=4, ch0=3; then duty extremes in both modes.
        applyStimulus(1'b1, 1'b1, 1'b1, 4, pack2(3, 1));
        runIdle(1'b1, 20);
        applyStimulus(1'b1, 1'b1, 1'b1, 4, pack2(4, 0));
        runIdle(1'b1, 20);
        applyStimulus(1'b1, 1'b1, 1'b0, 9, pack2(10, 0));
        runIdle(1'b1, 25);
        applyStimulus(1'b1, 1'b1, 1'b0, 9, pack2(0, 10));
        runIdle(1'b1, 25);

        // Enable gating at cnt=5 with a load while disabled.
        applyStimulus(1'b1, 1'b1, 1'b0, 9, pack2(6, 2));
        runIdle(1'b1, 12);
        for (int k = 0; k < 20 && model_cnt() != 5; k++)
            runIdle(1'b1, 1);
        runIdle(1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 3, pack2(2, 3));
        runIdle(1'b0, 2);
        runIdle(1'b1, 20);

        // Full-scale period wraps through all-ones.
        applyStimulus(1'b1, 1'b1, 1'b0, 255, pack2(200, 255));
        runIdle(1'b1, 530);

        // Randomized operation.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 24) == 0) begin
                p = ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 12);
                applyStimulus($urandom_range(0, 9) != 0, 1'b1, 1'($urandom_range(0, 1)), p,
                              pack2($urandom_range(0, (p + 2 > 255) ? 255 : p + 2),
                                    $urandom_range(0, (p + 2 > 255) ? 255 : p + 2)));
            end else begin
                runIdle($urandom_range(0, 9) != 0, 1);
            end
        end

        // Asynchronous reset mid-period with an uncommitted load.
        applyStimulus(1'b1, 1'b1, 1'b0, 20, pack2(12, 5));
        runIdle(1'b1, 30);
        applyStimulus(1'b1, 1'b1, 1'b0, 20, pack2(3, 3));
        runIdle(1'b1, 2);
        enable = 1'b0;
        load   = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset pwm_out", {30'd0, pwm_out}, 32'd0);
        checkOutput("async reset update_pending", {31'd0, update_pending}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        runIdle(1'b1, 10);
        applyStimulus(1'b1, 1'b1, 1'b1, 5, pack2(2, 5));
        runIdle(1'b1, 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
